fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one async_fifo among NUM_REQ producers in the write clock domain.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the write-port arbiter and async_fifo.
// master = arbiter view, slave = producer/FIFO environment view.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 8
);
   logic [NUM_REQ-1:0]            in_valid;
   logic [NUM_REQ-1:0]            in_last;
   logic [NUM_REQ*FIFO_WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]            in_ready;
   logic                          wfull;
   logic                          winc;
   logic [FIFO_WIDTH-1:0]         wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic                          busy;

   modport master (
      input  in_valid, in_last, in_data, wfull,
      output in_ready, winc, wdata, gnt, busy
   );

   modport slave (
      output in_valid, in_last, in_data, wfull,
      input  in_ready, winc, wdata, gnt, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-based arbiter sharing one async_fifo write port among NUM_REQ producers.
// Grant is held for a packet, up to MAX_BURST beats or until the owner idles for IDLE_TMO cycles.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   parameter int IDLE_TMO   = 8
) (
   input logic                  wclk,
   input logic                  wrst,
   fifo_wr_arbiter_if.master    bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam int TMO_W = $clog2(IDLE_TMO) + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state_q,    state_d;
   logic [IDX_W-1:0] gidx_q,     gidx_d;
   logic [IDX_W-1:0] last_idx_q, last_idx_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;

   logic [NUM_REQ-1:0]    grant_vec;
   logic [NUM_REQ-1:0]    ready_vec;
   logic                  accept;
   logic [FIFO_WIDTH-1:0] wdata_mux;

   // First requester after the previous owner, wrapping modulo NUM_REQ.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   last);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
      return pick;
   endfunction

   always_comb begin
      grant_vec = '0;
      ready_vec = '0;
      accept    = 1'b0;
      wdata_mux = '0;
      if (state_q == ST_BUSY) begin
         grant_vec = NUM_REQ'(1) << gidx_q;
         ready_vec = bus.wfull ? '0 : grant_vec;
         accept    = bus.in_valid[gidx_q] & ~bus.wfull;
         wdata_mux = bus.in_data[gidx_q*FIFO_WIDTH +: FIFO_WIDTH];
      end
   end

   assign bus.gnt      = grant_vec;
   assign bus.in_ready = ready_vec;
   assign bus.winc     = accept;
   assign bus.wdata    = wdata_mux;
   assign bus.busy     = (state_q == ST_BUSY);

   // A full FIFO freezes everything, including the idle timeout.
   always_comb begin
      state_d    = state_q;
      gidx_d     = gidx_q;
      last_idx_d = last_idx_q;
      beat_cnt_d = beat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.in_valid) begin
               gidx_d     = rr_pick(bus.in_valid, last_idx_q);
               state_d    = ST_BUSY;
               beat_cnt_d = '0;
               tmo_cnt_d  = '0;
            end
         end
         default: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               tmo_cnt_d  = '0;
               if (bus.in_last[gidx_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                  state_d    = ST_IDLE;
                  last_idx_d = gidx_q;
               end
            end else if (!bus.wfull) begin
               if (tmo_cnt_q == TMO_W'(IDLE_TMO - 1)) begin
                  state_d    = ST_IDLE;
                  last_idx_d = gidx_q;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q    <= ST_IDLE;
         gidx_q     <= '0;
         last_idx_q <= IDX_W'(NUM_REQ - 1);
         beat_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         gidx_q     <= gidx_d;
         last_idx_q <= last_idx_d;
         beat_cnt_q <= beat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive beats, expected write order
// is queued by hand and a monitor checks every winc beat against it.
module tb_fifo_wr_arbiter;

   localparam int NR  = 4;
   localparam int W   = 8;
   localparam int MB  = 16;
   localparam int TMO = 8;

   typedef struct {
      int         src;
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic wclk = 1'b0;
   logic wrst;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(MB), .IDLE_TMO(TMO)
   ) dut (
      .wclk(wclk),
      .wrst(wrst),
      .bus (bus)
   );

   exp_t       sbq[$];
   logic [8:0] srcQ[NR][$];
   logic [NR-1:0] drvAcc;
   logic [8:0] hd;
   exp_t       monE;
   int checks    = 0;
   int fails     = 0;
   int cycle     = 0;
   int lastBeat  = 0;
   int beatsSeen = 0;
   int b0;

   function automatic logic [7:0] mk(input int src, input int seq);
      return 8'(((src & 3) << 6) | (seq & 63));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic applyStimulus(input int src, input int seq, input bit last);
      srcQ[src].push_back({last, mk(src, seq)});
   endtask

   task automatic expectBeat(input int src, input int seq, input int gap);
      exp_t e;
      e.src  = src;
      e.data = mk(src, seq);
      e.gap  = gap;
      sbq.push_back(e);
   endtask

   task automatic expectSeg(input int src, input int from, input int to, input int firstGap);
      for (int k = from; k <= to; k++) expectBeat(src, k, (k == from) ? firstGap : 1);
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while (sbq.size() > 0 && n < budget) begin
         @(negedge wclk); #1;
         n++;
      end
      checkOutput(name, sbq.size(), 0);
      repeat (3) @(negedge wclk);
   endtask

   task automatic waitBeats(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (beatsSeen < target && n < budget) begin
         @(negedge wclk); #1;
         n++;
      end
      checkOutput(name, beatsSeen, target);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_gnt"},      bus.gnt,      0);
      checkOutput({tag, "_busy"},     bus.busy,     0);
      checkOutput({tag, "_winc"},     bus.winc,     0);
      checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
   endtask

   // Producer model: holds each beat until it is seen accepted, then presents the next.
   initial begin
      bus.in_valid = '0;
      bus.in_last  = '0;
      bus.in_data  = '0;
      forever begin
         @(negedge wclk);
         drvAcc = bus.in_valid & bus.in_ready;
         @(posedge wclk); #1;
         for (int i = 0; i < NR; i++) begin
            if (drvAcc[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
            if (srcQ[i].size() > 0) begin
               hd = srcQ[i][0];
               bus.in_valid[i]       = 1'b1;
               bus.in_last[i]        = hd[8];
               bus.in_data[i*W +: W] = hd[7:0];
            end else begin
               bus.in_valid[i] = 1'b0;
               bus.in_last[i]  = 1'b0;
            end
         end
      end
   end

   // Monitor: every FIFO write is matched against the head of the scoreboard.
   initial begin
      forever begin
         @(negedge wclk);
         cycle++;
         if (wrst === 1'b0 && bus.winc === 1'b1) begin
            beatsSeen++;
            checkOutput("winc_while_full", bus.wfull, 0);
            if (sbq.size() == 0) begin
               checkOutput("unexpected_beat_wdata", bus.wdata, 32'hFFFF_FFFF);
            end else begin
               monE = sbq.pop_front();
               checkOutput("wdata", bus.wdata, monE.data);
               checkOutput("gnt", bus.gnt, 32'(1) << monE.src);
               checkOutput("busy", bus.busy, 1);
               if (monE.gap > 0) checkOutput("beat_gap", cycle - lastBeat, monE.gap);
            end
            lastBeat = cycle;
         end
      end
   end

   initial begin
      wrst      = 1'b1;
      bus.wfull = 1'b0;

      // Reset with every producer valid, then two rounds of single-beat packets.
      $display("[TB] reset and round robin");
      for (int i = 0; i < NR; i++) begin
         applyStimulus(i, i, 1'b1);
         applyStimulus(i, 4 + i, 1'b1);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge wclk); #1;
         checkIdleOutputs("reset");
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++)
            expectBeat(i, 4*r + i, (r == 0 && i == 0) ? 0 : 2);
      @(negedge wclk);
      wrst = 1'b0;
      waitDrain("drain_round_robin", 60);

      // Long packet from req1 competing with req2: 16-beat bursts alternate.
      $display("[TB] burst limit");
      for (int k = 0; k < 40; k++) applyStimulus(1, k, k == 39);
      for (int k = 0; k < 20; k++) applyStimulus(2, k, k == 19);
      expectSeg(1, 0, 15, 0);
      expectSeg(2, 0, 15, 2);
      expectSeg(1, 16, 31, 2);
      expectSeg(2, 16, 19, 2);
      expectSeg(1, 32, 39, 2);
      waitDrain("drain_burst", 200);

      // FIFO full for 20 cycles in the middle of a req0 packet.
      $display("[TB] full stall");
      b0 = beatsSeen;
      for (int k = 0; k < 10; k++) applyStimulus(0, 8 + k, k == 9);
      expectSeg(0, 8, 11, 0);
      expectSeg(0, 12, 17, 0);
      expectBeat(3, 50, 2);
      waitBeats("beats_before_full", b0 + 4, 50);
      @(posedge wclk); #2;
      bus.wfull = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge wclk); #1;
         checkOutput("stall_winc", bus.winc, 0);
         checkOutput("stall_in_ready", bus.in_ready, 0);
         checkOutput("stall_gnt", bus.gnt, 1);
         checkOutput("stall_busy", bus.busy, 1);
         if (c == 5) applyStimulus(3, 50, 1'b1);
      end
      @(posedge wclk); #2;
      bus.wfull = 1'b0;
      #1;
      checkOutput("resume_winc", bus.winc, 1);
      checkOutput("resume_in_ready", bus.in_ready, 1);
      waitDrain("drain_full", 60);

      // req0 goes quiet after one beat: released after 8 idle cycles, req3 next.
      $display("[TB] idle timeout");
      applyStimulus(0, 20, 1'b0);
      applyStimulus(3, 21, 1'b1);
      expectBeat(0, 20, 0);
      expectBeat(3, 21, 10);
      waitDrain("drain_timeout", 60);

      // Reset after 5 beats of req2: partial packet dropped, req0 wins first.
      $display("[TB] reset mid-packet");
      b0 = beatsSeen;
      for (int k = 0; k < 10; k++) applyStimulus(2, 30 + k, k == 9);
      expectSeg(2, 30, 34, 0);
      waitBeats("beats_before_reset", b0 + 5, 60);
      @(posedge wclk); #2;
      wrst = 1'b1;
      for (int i = 0; i < NR; i++) srcQ[i].delete();
      checkOutput("sb_empty_at_reset", sbq.size(), 0);
      applyStimulus(0, 40, 1'b1);
      applyStimulus(2, 41, 1'b1);
      applyStimulus(3, 42, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge wclk); #1;
         checkIdleOutputs("midreset");
      end
      expectBeat(0, 40, 0);
      expectBeat(2, 41, 2);
      expectBeat(3, 42, 2);
      @(negedge wclk);
      wrst = 1'b0;
      waitDrain("drain_after_reset", 60);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
